// File: rtl/rca_pipelined.sv
// rca_pipelined: pipelined ripple-carry adder/subtractor with valid/ready
// handshakes on both sides.
//
// The operand is cut into CHUNK-bit slices; pipeline stage k ripples slice k
// and registers the slice carry for stage k+1. Untouched operand slices
// (B already inverted for subtraction) and the finished lower sum slices
// travel with the beat. The last stage register is the output register, so
// a beat accepted in cycle t is presented in cycle t+STAGES. Every stage
// advances together whenever the output slot is empty or being drained.
//
// WIDTH must be a multiple of CHUNK, and CHUNK must be at least 1.
//
// Optional build macro RCA_PIPELINED_FLAGS_EN adds registered zero/neg
// result flags aligned with sum.
module rca_pipelined #(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter int STAGES = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA_PIPELINED_FLAGS_EN
  output logic             zero,
  output logic             neg,
`endif
  output logic             ovf
);

  // Ripple one slice. Result layout: [CHUNK+1] carry into the slice's top
  // bit, [CHUNK] carry out of the slice, [CHUNK-1:0] slice sum.
  function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    logic             c;
    logic             c_top;
    logic [CHUNK-1:0] s;
    c     = ci;
    c_top = ci;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c_top = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c_top, c, s};
  endfunction

  // Stage registers: operands in flight, partial sum, slice carry, valid.
  logic [WIDTH-1:0] a_p [STAGES];
  logic [WIDTH-1:0] b_p [STAGES];
  logic [WIDTH-1:0] s_p [STAGES];
  logic             c_p [STAGES];
  logic             vld_p [STAGES];
  logic             ovf_p;
`ifdef RCA_PIPELINED_FLAGS_EN
  logic             zero_p;
  logic             neg_p;
`endif

  // Stage inputs (previous register or the incoming beat) and next values.
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic [CHUNK+1:0] rip   [STAGES];
  logic             nxt_msb_cin;
  logic             adv;

  assign adv       = !vld_p[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[STAGES-1];
  assign sum       = s_p[STAGES-1];
  assign cout      = c_p[STAGES-1];
  assign ovf       = ovf_p;
`ifdef RCA_PIPELINED_FLAGS_EN
  assign zero      = zero_p;
  assign neg       = neg_p;
`endif

  // Per-stage slice ripple; stage 0 sees the conditioned input operands.
  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_s[0] = '0;
    src_c[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_p[k-1];
      src_b[k] = b_p[k-1];
      src_s[k] = s_p[k-1];
      src_c[k] = c_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      rip[k]                     = ripple(src_a[k][k*CHUNK +: CHUNK],
                                          src_b[k][k*CHUNK +: CHUNK], src_c[k]);
      nxt_s[k]                   = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = rip[k][CHUNK-1:0];
      nxt_c[k]                   = rip[k][CHUNK];
    end
    nxt_msb_cin = rip[STAGES-1][CHUNK+1];
  end

  // Pipeline advance: all stages shift together, or all hold when stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        s_p[k]   <= '0;
        c_p[k]   <= 1'b0;
        vld_p[k] <= 1'b0;
      end
      ovf_p <= 1'b0;
`ifdef RCA_PIPELINED_FLAGS_EN
      zero_p <= 1'b0;
      neg_p  <= 1'b0;
`endif
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= src_a[k];
        b_p[k] <= src_b[k];
        s_p[k] <= nxt_s[k];
        c_p[k] <= nxt_c[k];
      end
      ovf_p <= nxt_msb_cin ^ nxt_c[STAGES-1];
`ifdef RCA_PIPELINED_FLAGS_EN
      zero_p <= (nxt_s[STAGES-1] == '0);
      neg_p  <= nxt_s[STAGES-1][WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_rca_pipelined.sv
// Testbench for rca_pipelined: directed 32-bit vector table, streaming,
// stall and reset sequences, plus randomised 16/4 and 8/8 instances
// checked against a behavioural adder model.
module tb_rca_pipelined;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit, CHUNK=8 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf;
`ifdef RCA_PIPELINED_FLAGS_EN
  logic        zero, neg;
`endif

  rca_pipelined #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout),
`ifdef RCA_PIPELINED_FLAGS_EN
    .zero(zero), .neg(neg),
`endif
    .ovf(ovf));

  // 16-bit, CHUNK=4 instance
  logic        iv16, ir16, ov16, or16, cin16, sub16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
`ifdef RCA_PIPELINED_FLAGS_EN
  logic        zero16, neg16;
`endif

  rca_pipelined #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(ov16),
    .out_ready(or16), .sum(sum16), .cout(cout16),
`ifdef RCA_PIPELINED_FLAGS_EN
    .zero(zero16), .neg(neg16),
`endif
    .ovf(ovf16));

  // 8-bit, CHUNK=8 instance (single stage)
  logic       iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
`ifdef RCA_PIPELINED_FLAGS_EN
  logic       zero8, neg8;
`endif

  rca_pipelined #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8),
    .out_ready(or8), .sum(sum8), .cout(cout8),
`ifdef RCA_PIPELINED_FLAGS_EN
    .zero(zero8), .neg(neg8),
`endif
    .ovf(ovf8));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: returns {ovf, cout, sum[31:0]} for a w-bit add/sub.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb, input int w);
    logic [31:0] mask, xm, ym, s;
    logic [32:0] full;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    xm   = x & mask;
    ym   = (sb ? ~y : y) & mask;
    full = {1'b0, xm} + {1'b0, ym} + (sb ? 33'd1 : {32'd0, ci});
    co   = full[w];
    s    = full[31:0] & mask;
    ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tab[10];

  // Single beat on the 32-bit instance: checks latency of exactly 4 cycles.
  task automatic run_one(input vec_t v, input string tag);
    out_ready = 1'b1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check({tag, " early"}, 64'(out_valid), 64'd0);
    step();
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " sum"}, 64'(sum), 64'(v.s));
    check({tag, " cout"}, 64'(cout), 64'(v.co));
    check({tag, " ovf"}, 64'(ovf), 64'(v.ov));
`ifdef RCA_PIPELINED_FLAGS_EN
    check({tag, " zero"}, 64'(zero), 64'(v.s == 32'd0));
    check({tag, " neg"}, 64'(neg), 64'(v.s[31]));
`endif
    step();
  endtask

  // Random stream on the 16/4 instance with latency check against STAGES=4.
  task automatic rand16(input int n);
    logic [33:0] q[$];
    int          tq[$];
    logic [33:0] e;
    int          t0;
    or16 = 1'b1;
    for (int m = 0; m < n + 8; m++) begin
      if (ov16) begin
        if (q.size() == 0) check("r16 extra beat", 64'd1, 64'd0);
        else begin
          e  = q.pop_front();
          t0 = tq.pop_front();
          check("r16 result", 64'({ovf16, cout16, 16'h0, sum16}), 64'(e));
          check("r16 latency", 64'(m - t0), 64'd4);
        end
      end
      if (m < n) begin
        iv16 = 1'b1;
        if (m == 0)      begin a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 0; sub16 = 0; end
        else if (m == 1) begin a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 0; sub16 = 0; end
        else begin
          a16 = 16'($urandom); b16 = 16'($urandom);
          cin16 = 1'($urandom); sub16 = 1'($urandom);
        end
      end else iv16 = 1'b0;
      #1;
      if (iv16 && ir16) begin
        q.push_back(model({16'h0, a16}, {16'h0, b16}, cin16, sub16, 16));
        tq.push_back(m);
      end
      @(posedge clk);
      #1;
    end
    check("r16 drained", 64'(q.size()), 64'd0);
  endtask

  // Random stream on the 8/8 instance with latency check against STAGES=1.
  task automatic rand8(input int n);
    logic [33:0] q[$];
    int          tq[$];
    logic [33:0] e;
    int          t0;
    or8 = 1'b1;
    for (int m = 0; m < n + 8; m++) begin
      if (ov8) begin
        if (q.size() == 0) check("r8 extra beat", 64'd1, 64'd0);
        else begin
          e  = q.pop_front();
          t0 = tq.pop_front();
          check("r8 result", 64'({ovf8, cout8, 24'h0, sum8}), 64'(e));
          check("r8 latency", 64'(m - t0), 64'd1);
        end
      end
      if (m < n) begin
        iv8 = 1'b1;
        if (m == 0)      begin a8 = 8'hFF; b8 = 8'h01; cin8 = 0; sub8 = 0; end
        else if (m == 1) begin a8 = 8'h7F; b8 = 8'h01; cin8 = 0; sub8 = 0; end
        else begin
          a8 = 8'($urandom); b8 = 8'($urandom);
          cin8 = 1'($urandom); sub8 = 1'($urandom);
        end
      end else iv8 = 1'b0;
      #1;
      if (iv8 && ir8) begin
        q.push_back(model({24'h0, a8}, {24'h0, b8}, cin8, sub8, 8));
        tq.push_back(m);
      end
      @(posedge clk);
      #1;
    end
    check("r8 drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [33:0] e;
    logic [33:0] exp_q[6];
    logic [31:0] held_sum;
    logic        held_c, stalled;
    int          tx, rx, first;

    //          a             b             cin   sub   sum           cout  ovf
    tab[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tab[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tab[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tab[3] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0};
    tab[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tab[5] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tab[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tab[7] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tab[8] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    tab[9] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
    iv16 = 0; or16 = 1; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;

    // Reset state
    step();
    step();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    #2 rst = 1'b0;
    #1 check("post-reset in_ready", 64'(in_ready), 64'd1);
    step();

    // Directed vector table
    for (int i = 0; i < 10; i++) run_one(tab[i], $sformatf("vec%0d", i));

    // Back-to-back stream of 8 beats, results at +4 with no gaps
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (n < 8) begin
        in_valid = 1'b1; a = 32'(n); b = 32'(n) * 32'h0101_0101; cin = 0; sub = 0;
      end else in_valid = 1'b0;
      step();
      if (n >= 3 && n < 11) begin
        e = model(32'(n - 3), 32'(n - 3) * 32'h0101_0101, 1'b0, 1'b0, 32);
        check($sformatf("stream%0d valid", n - 3), 64'(out_valid), 64'd1);
        check($sformatf("stream%0d sum", n - 3), 64'({ovf, cout, sum}), 64'(e));
      end else begin
        check($sformatf("stream idle%0d", n), 64'(out_valid), 64'd0);
      end
    end

    // Stream 6 beats, stall output for 5 cycles after first result
    for (int i = 0; i < 6; i++)
      exp_q[i] = model(32'hF000_0000 + 32'(i), 32'h1000_0001 * 32'(i), 1'b1, 1'(i), 32);
    tx = 0; rx = 0; first = -1; held_sum = '0; held_c = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid && first < 0) begin
        first = n; held_sum = sum; held_c = cout;
      end
      stalled = (first >= 0) && (n < first + 5);
      out_ready = !stalled;
      if (tx < 6) begin
        in_valid = 1'b1; a = 32'hF000_0000 + 32'(tx); b = 32'h1000_0001 * 32'(tx);
        cin = 1'b1; sub = 1'(tx);
      end else in_valid = 1'b0;
      #1;
      if (stalled && n > first) begin
        check("stall in_ready", 64'(in_ready), 64'd0);
        check("stall out_valid", 64'(out_valid), 64'd1);
        check("stall hold", 64'({cout, sum}), 64'({held_c, held_sum}));
      end
      if (out_valid && out_ready) begin
        if (rx < 6) check($sformatf("stall beat%0d", rx), 64'({ovf, cout, sum}), 64'(exp_q[rx]));
        else        check("stall extra beat", 64'd1, 64'd0);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk);
      #1;
    end
    check("stall beats out", 64'(rx), 64'd6);
    check("stall beats in", 64'(tx), 64'd6);
    out_ready = 1'b1;
    in_valid  = 1'b0;

    // Reset with 3 beats in flight
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; a = 32'hAAAA_0000 + 32'(n); b = 32'h0000_1111; cin = 0; sub = 0;
      step();
    end
    in_valid = 1'b0;
    step();
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset sum", 64'(sum), 64'd0);
    check("async reset cout", 64'(cout), 64'd0);
    check("async reset ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("reset release in_ready", 64'(in_ready), 64'd1);
    for (int n = 0; n < 6; n++) begin
      step();
      check("no stale beat", 64'(out_valid), 64'd0);
    end
    run_one(tab[1], "after-reset");

    // Randomised narrower configurations against the model
    fork
      rand16(10000);
      rand8(10000);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_pipelined.md
Name: rca_pipelined

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed-width combinational ripple-carry adders.
- Operand is split into CHUNK-bit slices. Each pipeline stage ripples one slice and registers the carry into the next stage.
- Operands enter and results leave through valid/ready handshakes, so the block drops into ALU datapaths that run at clock rates a full-width ripple chain cannot meet.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits rippled per pipeline stage; must be ≥1.
- STAGES, WIDTH/CHUNK: derived pipeline depth; not overridden by instantiators.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 = A+B+cin; 1 = A−B, computed as A+~B+1.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH−1; for sub, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, rst=1):
  - All stage valid bits, data registers and outputs clear immediately.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 once rst deasserts.
  - Beats in flight when reset asserts are discarded; none emerge after reset.
- Advance rule: adv = !out_valid || out_ready. Define in_ready = adv (combinational).
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - When adv=0, every stage holds: data, carries and valid bits are unchanged.
- Pipeline: stage k (k=0..STAGES−1) ripples slice k (bits k*CHUNK .. k*CHUNK+CHUNK−1).
  - Slice k's carry-in is the carry registered by stage k−1.
  - Stage 0 carry-in is sub ? 1 : cin.
  - Operand slices above k travel unmodified (B already inverted if sub) alongside the beat.
  - Completed lower sum slices travel with the beat.
- Latency: a beat accepted in cycle t gives out_valid=1 in cycle t+STAGES when no stall occurs. Throughput is one beat per cycle.
- Bubbles: cycles with in_valid=0 on an accepted slot insert invalid stages. Bubbles move like data; there is no compaction.
- Outputs sum/cout/ovf are registered. They hold stable while out_valid=1 && out_ready=0.
- Width arithmetic: sum is modulo 2^WIDTH.
  - cout is bit WIDTH of the full WIDTH+1-bit sum.
  - ovf uses the carries into and out of bit WIDTH−1. The carry into bit WIDTH−1 is kept from the final stage's internal ripple.
- Simultaneous in/out transfer in the same cycle is legal; the pipeline shifts by one.
- STAGES=1 degenerates to one registered full-width ripple with latency 1.
- No reordering and no dropping: output order equals acceptance order.

Optional Feature:
- Macro: RCA_PIPELINED_FLAGS_EN.
- Defined: adds two output ports, registered and aligned with sum; both reset to 0.
  - zero  out  1: 1 when sum == 0.
  - neg  out  1: equal to sum[WIDTH−1].
- Undefined: the zero and neg ports and their logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=32, CHUNK=8, out_ready=1; a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 → 4 cycles later: sum=0x0000_0000, cout=1, ovf=0 (zero=1, neg=0 if flags enabled).
- a=0x7FFF_FFFF, b=0x0000_0001, sub=0 → sum=0x8000_0000, cout=0, ovf=1 (neg=1). Then a=5, b=7, sub=1, cin=1 → sum=0xFFFF_FFFE, cout=0, ovf=0; cin is ignored.
- Back-to-back stream of 8 beats, a=i, b=i*0x0101_0101, one per cycle → 8 consecutive results in order, first at +4 cycles, no gaps.
- Stream 6 beats; hold out_ready=0 for 5 cycles after the first result appears → in_ready=0 during the stall, outputs stable, no beat lost or duplicated; results resume in order when out_ready=1.
- Assert rst for 1 cycle while 3 beats are in flight → out_valid falls immediately, all outputs 0; no stale beat appears; a new beat accepted after reset returns at +4 cycles.
- Re-run the first two scenarios with WIDTH=16, CHUNK=4 and with WIDTH=8, CHUNK=8 → latency equals STAGES (4 and 1); results are bit-exact versus a reference model for 10k random operands with sub and cin randomised.
